memory_load_controller: RTL and testbench

//  Sequences parameter loading (weights/delays) into the M x N memory array of the SNN core.

---
 rtl/snn_mem_pkg.sv | 16 +
 rtl/memory_load_controller.sv | 115 +++++++++++
 tb/tb_memory_load_controller.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/snn_mem_pkg.sv
// Shared definitions for the SNN memory sequencers: FSM state encoding and
// the address-width helper used to size memory address ports.
package snn_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } mem_seq_state_e;

   // Keeps a single-word memory at a 1-bit address instead of zero width.
   function automatic int unsigned addr_width(input int unsigned depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/memory_load_controller.sv
// Streams M parameter words into the SNN core memory with an auto-incrementing
// address, and shares the memory address port with host readback (load wins).
module memory_load_controller
   import snn_mem_pkg::*;
#(
   parameter  int unsigned M      = 10,
   parameter  int unsigned N      = 8,
   localparam int unsigned ADDR_W = addr_width(M)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [N-1:0]      data_in,
   input  logic              data_valid,
   output logic              data_ready,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_grant,
   output logic [N-1:0]      rd_data,
   output logic              rd_valid,
   output logic [N-1:0]      mem_data_in,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_write_enable,
   input  logic [N-1:0]      mem_data_out,
   output logic              busy,
   output logic              load_done,
   output logic              overflow,
   output logic [ADDR_W:0]   words_loaded
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(M - 1);
   localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

   mem_seq_state_e    state_q;
   logic [ADDR_W-1:0] wr_ptr_q;
   logic [ADDR_W:0]   words_q;
   logic              done_q;
   logic              ovf_q;
   logic              rd_valid_q;
   logic [N-1:0]      rd_data_q;
   logic              wr_fire;

   always_comb begin
      data_ready       = (state_q == LOAD) && !start;
      wr_fire          = data_valid && data_ready;
      rd_grant         = rd_en && (state_q != LOAD);
      mem_write_enable = wr_fire;
      mem_data_in      = wr_fire ? data_in : '0;
      mem_addr         = '0;
      if (wr_fire) begin
         mem_addr = wr_ptr_q;
      end else if (rd_grant) begin
         mem_addr = rd_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         words_q    <= '0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= rd_grant;
         if (rd_grant) begin
            rd_data_q <= mem_data_out;
         end

         // Any start clears overflow; it can only be raised outside LOAD.
         if (start) begin
            ovf_q <= 1'b0;
         end else if (data_valid && (state_q != LOAD)) begin
            ovf_q <= 1'b1;
         end

         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q  <= LOAD;
                  wr_ptr_q <= '0;
                  words_q  <= '0;
                  done_q   <= 1'b0;
               end
            end
            LOAD: begin
               if (start) begin
                  wr_ptr_q <= '0;
                  words_q  <= '0;
               end else if (wr_fire) begin
                  words_q <= words_q + CNT_ONE;
                  if (wr_ptr_q == LAST_ADDR) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     wr_ptr_q <= wr_ptr_q + PTR_ONE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy         = (state_q == LOAD);
   assign load_done    = done_q;
   assign overflow     = ovf_q;
   assign words_loaded = words_q;
   assign rd_valid     = rd_valid_q;
   assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_memory_load_controller.sv
// Scoreboard bench for memory_load_controller with a behavioural memory attached.
module tb_memory_load_controller;

   localparam int unsigned M = 10;
   localparam int unsigned N = 8;
   localparam int unsigned AW = 4;

   logic          clk = 1'b0;
   logic          reset, start, data_valid, rd_en;
   logic [N-1:0]  data_in;
   logic [AW-1:0] rd_addr;
   logic          data_ready, rd_grant, rd_valid, mem_write_enable;
   logic          busy, load_done, overflow;
   logic [N-1:0]  rd_data, mem_data_in, mem_data_out;
   logic [AW-1:0] mem_addr;
   logic [AW:0]   words_loaded;

   logic [N-1:0]  mem [0:15];

   int checks   = 0;
   int failures = 0;

   logic [AW+N-1:0] exp_wr[$];
   logic [N-1:0]    exp_rd[$];

   always #5 clk = ~clk;

   memory_load_controller #(.M(M), .N(N)) dut (
      .clk(clk), .reset(reset), .start(start), .data_in(data_in),
      .data_valid(data_valid), .data_ready(data_ready), .rd_en(rd_en),
      .rd_addr(rd_addr), .rd_grant(rd_grant), .rd_data(rd_data),
      .rd_valid(rd_valid), .mem_data_in(mem_data_in), .mem_addr(mem_addr),
      .mem_write_enable(mem_write_enable), .mem_data_out(mem_data_out),
      .busy(busy), .load_done(load_done), .overflow(overflow),
      .words_loaded(words_loaded)
   );

   always @(posedge clk) begin
      if (mem_write_enable) mem[mem_addr] <= mem_data_in;
   end
   assign mem_data_out = mem[mem_addr];

   function automatic logic [79:0] all_data_out();
      logic [79:0] v;
      v = '0;
      for (int i = 0; i < 10; i++) v[i*8 +: 8] = mem[i];
      return v;
   endfunction

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: every write and every readback must match the next queued expectation.
   always @(negedge clk) begin
      if (mem_write_enable) begin
         if (exp_wr.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual=addr %0h data %0h required=no write",
                     mem_addr, mem_data_in);
         end else begin
            chk("write_addr_data", {68'd0, mem_addr, mem_data_in}, {68'd0, exp_wr.pop_front()});
         end
      end
      if (rd_valid) begin
         if (exp_rd.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rd_valid actual=data %0h required=no rd_valid", rd_data);
         end else begin
            chk("rd_data", {72'd0, rd_data}, {72'd0, exp_rd.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      #1;
   endtask

   task automatic send(input logic [AW-1:0] a, input logic [N-1:0] d);
      data_valid = 1'b1;
      data_in    = d;
      exp_wr.push_back({a, d});
      tick();
      data_valid = 1'b0;
      data_in    = '0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = '0;
      reset = 1'b1; start = 1'b0; data_valid = 1'b0; rd_en = 1'b0;
      data_in = '0; rd_addr = '0;
      tick(); tick();
      reset = 1'b0;
      sample();
      chk("reset_busy", {79'd0, busy}, 80'd0);
      chk("reset_load_done", {79'd0, load_done}, 80'd0);
      chk("reset_overflow", {79'd0, overflow}, 80'd0);
      chk("reset_words", {75'd0, words_loaded}, 80'd0);
      chk("reset_rd_data", {71'd0, rd_valid, rd_data}, 80'd0);
      chk("reset_ready_addr", {75'd0, data_ready, mem_addr}, 80'd0);

      // 1: back-to-back stream
      pulse_start();
      sample();
      chk("t1_busy_ready", {78'd0, busy, data_ready}, 80'd3);
      for (int i = 0; i < 10; i++) begin
         send(AW'(i), N'(i + 1));
         if (i == 8) begin
            sample();
            chk("t1_done_before_last", {74'd0, load_done, words_loaded}, {74'd0, 1'b0, 5'd9});
         end
      end
      sample();
      chk("t1_done_words", {74'd0, load_done, words_loaded}, {74'd0, 1'b1, 5'd10});
      chk("t1_idle_after", {78'd0, busy, data_ready}, 80'd0);
      chk("t1_contents", all_data_out(), 80'h0A090807060504030201);

      // 2: stream with a gap after every word
      pulse_start();
      for (int i = 0; i < 10; i++) begin
         send(AW'(i), N'(i + 1));
         if (i < 9) begin
            sample();
            chk("t2_busy_gap", {79'd0, busy}, 80'd1);
            tick();
         end
      end
      sample();
      chk("t2_done_words", {74'd0, load_done, words_loaded}, {74'd0, 1'b1, 5'd10});
      chk("t2_contents", all_data_out(), 80'h0A090807060504030201);

      // 3: readback refused during LOAD, granted after DONE
      pulse_start();
      rd_en = 1'b1; rd_addr = 4'd3;
      sample();
      chk("t3_grant_in_load", {79'd0, rd_grant}, 80'd0);
      tick();
      rd_en = 1'b0;
      sample();
      chk("t3_no_rd_valid", {79'd0, rd_valid}, 80'd0);
      for (int i = 0; i < 10; i++) send(AW'(i), N'(i + 1));
      rd_en = 1'b1; rd_addr = 4'd3;
      exp_rd.push_back(8'h04);
      sample();
      chk("t3_grant_addr", {75'd0, rd_grant, mem_addr}, {75'd0, 1'b1, 4'd3});
      tick();
      rd_en = 1'b0;
      sample();
      chk("t3_rd_valid_data", {71'd0, rd_valid, rd_data}, {71'd0, 1'b1, 8'h04});
      tick();
      sample();
      chk("t3_rd_hold", {71'd0, rd_valid, rd_data}, {71'd0, 1'b0, 8'h04});

      // simultaneous start and read in DONE: read wins this cycle, LOAD next
      start = 1'b1; rd_en = 1'b1; rd_addr = 4'd7;
      exp_rd.push_back(8'h08);
      sample();
      chk("t3_start_rd_grant", {78'd0, rd_grant, busy}, {78'd0, 1'b1, 1'b0});
      tick();
      start = 1'b0; rd_en = 1'b0;
      sample();
      chk("t3_start_rd_next", {78'd0, busy, rd_valid}, 80'd3);

      // 4: restart after 5 words; start-cycle word is dropped
      for (int i = 0; i < 5; i++) send(AW'(i), N'(8'h55 + i));
      start = 1'b1; data_valid = 1'b1; data_in = 8'hEE;
      sample();
      chk("t4_restart_ready_we", {78'd0, data_ready, mem_write_enable}, 80'd0);
      tick();
      start = 1'b0; data_valid = 1'b0;
      sample();
      chk("t4_restart_words", {74'd0, busy, words_loaded}, {74'd0, 1'b1, 5'd0});
      for (int i = 0; i < 10; i++) begin
         send(AW'(i), N'(8'hA0 + i));
         if (i == 8) begin
            sample();
            chk("t4_done_before_last", {74'd0, load_done, words_loaded}, {74'd0, 1'b0, 5'd9});
         end
      end
      sample();
      chk("t4_done_words", {74'd0, load_done, words_loaded}, {74'd0, 1'b1, 5'd10});
      chk("t4_contents", all_data_out(), 80'hA9A8A7A6A5A4A3A2A1A0);

      // 5: overflow in DONE and in IDLE, cleared by start
      data_valid = 1'b1; data_in = 8'hFF;
      sample();
      chk("t5_done_no_write", {79'd0, mem_write_enable}, 80'd0);
      tick();
      data_valid = 1'b0;
      sample();
      chk("t5_overflow_done", {78'd0, overflow, load_done}, 80'd3);
      pulse_start();
      sample();
      chk("t5_start_clears", {77'd0, overflow, load_done, busy}, {77'd0, 3'b001});
      reset = 1'b1;
      tick();
      reset = 1'b0;
      data_valid = 1'b1; data_in = 8'h77;
      sample();
      chk("t5_idle_ready", {78'd0, data_ready, mem_write_enable}, 80'd0);
      tick();
      data_valid = 1'b0;
      sample();
      chk("t5_overflow_idle", {79'd0, overflow}, 80'd1);
      pulse_start();
      sample();
      chk("t5_start_clears_idle", {74'd0, overflow, words_loaded}, 80'd0);

      // 6: reset mid-load keeps partial data
      for (int i = 0; i < 4; i++) send(AW'(i), N'(8'hC0 + i));
      sample();
      chk("t6_words4", {75'd0, words_loaded}, 80'd4);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sample();
      chk("t6_reset_state", {73'd0, busy, load_done, words_loaded}, 80'd0);
      chk("t6_contents", all_data_out(), 80'hA9A8A7A6A5A4C3C2C1C0);

      tick(); tick();
      chk("wr_queue_empty", 80'(exp_wr.size()), 80'd0);
      chk("rd_queue_empty", 80'(exp_rd.size()), 80'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
